adder_seq_ctrl: RTL

Sequencing controller for the board-level adder: takes one-cycle key-edge pulses and switch data, captures operand A then operand B, and runs a bit-serial add over WIDTH cycles. It presents sum, carry and state for LEDs/display. It sits between the key-edge detectors, which supply debounced single-cycle pulses, and the display logic.

---
 rtl/adder_pkg.sv | 10 +
 rtl/adder_seq_ctrl_if.sv | 16 +
 rtl/full_adder_bit.sv | 11 +
 rtl/adder_seq_ctrl.sv | 79 +++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: state codes and default operand width shared by the adder controller and display decoder.
package adder_pkg;
    localparam int WIDTH_DEF = 4;
    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_ADD  = 2'd2,
        S_SHOW = 2'd3
    } state_t;
endpackage

// File: rtl/adder_seq_ctrl_if.sv
// adder_seq_ctrl_if: key/clear/switch inputs and result/status outputs of the adder controller.
interface adder_seq_ctrl_if #(parameter int WIDTH = adder_pkg::WIDTH_DEF);
    import adder_pkg::*;
    logic             key;
    logic             clr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [1:0]       state;
    logic             busy;
    logic             done;
    modport master (output key, clr, din, input a_q, b_q, sum, cout, state, busy, done);
    modport slave  (input key, clr, din, output a_q, b_q, sum, cout, state, busy, done);
endinterface

// File: rtl/full_adder_bit.sv
// full_adder_bit: combinational one-bit full adder.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: captures operands A and B on key pulses, then adds them bit-serially over WIDTH cycles.
module adder_seq_ctrl #(parameter int WIDTH = adder_pkg::WIDTH_DEF) (
    input  logic             clk,
    input  logic             rst_n,
    adder_seq_ctrl_if.slave  bus
);
    import adder_pkg::*;
    localparam int CW = $clog2(WIDTH);
    state_t           st, nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q, b_q, sum;
    logic             c, cout, done, last, fa_s, fa_co;
    assign last = cnt == CW'(WIDTH - 1);
    full_adder_bit u_fa (
        .a   (a_q[cnt]),
        .b   (b_q[cnt]),
        .cin (c),
        .s   (fa_s),
        .co  (fa_co)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= S_A;
        else        st <= nxt;
    end
    // clr overrides every transition, including a simultaneous key
    always_comb begin
        nxt = st;
        case (st)
            S_A:    nxt = bus.key ? S_B : S_A;
            S_B:    nxt = bus.key ? S_ADD : S_B;
            S_ADD:  nxt = last ? S_SHOW : S_ADD;
            S_SHOW: nxt = bus.key ? S_A : S_SHOW;
        endcase
        if (bus.clr) nxt = S_A;
    end
    always_comb begin
        bus.state = st;
        bus.busy  = st == S_ADD;
        bus.done  = done;
        bus.a_q   = a_q;
        bus.b_q   = b_q;
        bus.sum   = sum;
        bus.cout  = cout;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            sum  <= '0;
            cout <= 1'b0;
            c    <= 1'b0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= st == S_ADD && nxt == S_SHOW;
            if (bus.clr) begin
                a_q  <= '0;
                b_q  <= '0;
                sum  <= '0;
                cout <= 1'b0;
                c    <= 1'b0;
                cnt  <= '0;
            end else if (st == S_A && bus.key) begin
                a_q <= bus.din;
            end else if (st == S_B && bus.key) begin
                b_q  <= bus.din;
                sum  <= '0;
                cout <= 1'b0;
                c    <= 1'b0;
                cnt  <= '0;
            end else if (st == S_ADD) begin
                sum[cnt] <= fa_s;
                c        <= fa_co;
                if (last) cout <= fa_co;
                else      cnt  <= cnt + 1'b1;
            end
        end
    end
endmodule
